// File: rtl/clock_generator_if.sv
// Control and status bundle of the programmable system-clock generator.
// The master drives the run request and ratio; the slave returns the clock, strobes and cycle count.
interface clock_generator_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 32
);
  logic             enable;
  logic [DIV_W-1:0] div_sel;
  logic             clock;
  logic             clock_rise;
  logic             clock_fall;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output enable,
    output div_sel,
    input  clock,
    input  clock_rise,
    input  clock_fall,
    input  cycle_count
  );

  modport slave (
    input  enable,
    input  div_sel,
    output clock,
    output clock_rise,
    output clock_fall,
    output cycle_count
  );
endinterface

// File: rtl/clock_generator.sv
// Glitch-free 50%-duty programmable divider producing the processor clock from clk,
// with registered edge strobes and a wrapping count of completed rising edges.
module clock_generator #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 5,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  clock_generator_if.slave    bus
);

  localparam logic [DIV_W-1:0] DEF_HP =
    (DEFAULT_HALF == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_HALF);

  typedef enum logic {
    ST_PARKED,
    ST_RUN
  } state_t;

  state_t           state;
  logic             fresh;
  logic [DIV_W-1:0] hp_active;
  logic [DIV_W-1:0] hp_cur;
  logic [DIV_W-1:0] phase_cnt;
  logic             clock_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] count_q;

  logic [DIV_W-1:0] hp_req;
  logic [DIV_W-1:0] hp_wake;
  logic             phase_end;

  // hp_cur is the length of the phase in progress; hp_active only takes over
  // at the next rise, so a ratio change never shortens the current period.
  always_comb begin
    hp_req    = (bus.div_sel == '0) ? DIV_W'(1) : bus.div_sel;
    hp_wake   = fresh ? hp_active : hp_req;
    phase_end = (phase_cnt == hp_cur - DIV_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PARKED;
      fresh     <= 1'b1;
      hp_active <= DEF_HP;
      hp_cur    <= DEF_HP;
      phase_cnt <= '0;
      clock_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fresh  <= 1'b0;
      case (state)
        ST_PARKED: begin
          hp_active <= hp_wake;
          if (bus.enable) begin
            state  <= ST_RUN;
            hp_cur <= hp_wake;
            // The waking edge is the first counted edge of the low phase.
            if (hp_wake == DIV_W'(1)) begin
              clock_q   <= 1'b1;
              rise_q    <= 1'b1;
              count_q   <= count_q + CNT_W'(1);
              phase_cnt <= '0;
            end else begin
              phase_cnt <= DIV_W'(1);
            end
          end
        end
        default: begin
          if (!phase_end) begin
            phase_cnt <= phase_cnt + DIV_W'(1);
          end else begin
            phase_cnt <= '0;
            if (clock_q) begin
              clock_q   <= 1'b0;
              fall_q    <= 1'b1;
              hp_active <= hp_req;
              if (!bus.enable) state <= ST_PARKED;
            end else if (bus.enable) begin
              clock_q <= 1'b1;
              rise_q  <= 1'b1;
              count_q <= count_q + CNT_W'(1);
              hp_cur  <= hp_active;
            end else begin
              state <= ST_PARKED;
            end
          end
        end
      endcase
    end
  end

  assign bus.clock       = clock_q;
  assign bus.clock_rise  = rise_q;
  assign bus.clock_fall  = fall_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_clock_generator.sv
// Directed self-checking bench for clock_generator: default ratio, ratio change,
// div_sel 0/1, enable drop and re-enable, async reset, and cycle counter wrap.
module tb_clock_generator;

  logic clk;
  logic rst_n;
  int   edgeNum;
  int   assertionCount;
  int   failCount;

  clock_generator_if #(.DIV_W(8), .CNT_W(32)) dutIf ();
  clock_generator_if #(.DIV_W(8), .CNT_W(4))  wrapIf ();

  clock_generator #(.DIV_W(8), .DEFAULT_HALF(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dutIf.slave)
  );

  clock_generator #(.DIV_W(8), .DEFAULT_HALF(1), .CNT_W(4)) wrapDut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wrapIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertionCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s edge=%0d got=%0h expected=%0h", tag, edgeNum, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] sel);
    dutIf.enable  = en;
    dutIf.div_sel = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  // Holds reset across a clk edge, then releases on a falling edge so the next rise is edge 1.
  task automatic resetDut(input logic en, input logic [7:0] sel);
    rst_n = 1'b0;
    applyStimulus(en, sel);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    edgeNum = 0;
  endtask

  task automatic checkEdge(input logic expClock, input logic expRise, input logic expFall);
    checkOutput("clock", 32'(dutIf.clock), 32'(expClock));
    checkOutput("clock_rise", 32'(dutIf.clock_rise), 32'(expRise));
    checkOutput("clock_fall", 32'(dutIf.clock_fall), 32'(expFall));
  endtask

  initial begin
    assertionCount = 0;
    failCount      = 0;
    edgeNum        = 0;
    wrapIf.enable  = 1'b0;
    wrapIf.div_sel = 8'd1;
    rst_n          = 1'b0;
    applyStimulus(1'b1, 8'd5);
    #12;
    checkOutput("reset_clock", 32'(dutIf.clock), 32'd0);
    checkOutput("reset_rise", 32'(dutIf.clock_rise), 32'd0);
    checkOutput("reset_fall", 32'(dutIf.clock_fall), 32'd0);
    checkOutput("reset_count", dutIf.cycle_count, 32'd0);

    // Default ratio: rise at 5, 15, 25; fall at 10, 20.
    resetDut(1'b1, 8'd5);
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e < 5) checkEdge(1'b0, 1'b0, 1'b0);
      else checkEdge(((e - 5) % 10) < 5, ((e - 5) % 10) == 0, ((e - 5) % 10) == 5);
    end
    checkOutput("count_after_25", dutIf.cycle_count, 32'd3);

    // Ratio change mid-high: high ends at 30, low lasts 5, then period 4 from edge 35.
    for (int e = 26; e <= 46; e++) begin
      tick();
      if (e == 26) applyStimulus(1'b1, 8'd2);
      if (e <= 29) checkOutput("hp_change_high", 32'(dutIf.clock), 32'd1);
      else if (e <= 34) checkOutput("hp_change_low", 32'(dutIf.clock), 32'd0);
      else checkOutput("hp2_clock", 32'(dutIf.clock), 32'(((e - 35) % 4) < 2));
    end
    checkOutput("count_after_46", dutIf.cycle_count, 32'd6);

    // div_sel=0 behaves as 1: first period default, then toggle every edge from 15.
    resetDut(1'b1, 8'd0);
    for (int e = 1; e <= 28; e++) begin
      tick();
      if (e == 24) begin
        checkOutput("count_sel0", dutIf.cycle_count, 32'd6);
        applyStimulus(1'b1, 8'd1);
      end
      if (e >= 15) checkEdge(((e - 15) % 2) == 0, ((e - 15) % 2) == 0, ((e - 15) % 2) == 1);
      else if (e == 10) checkEdge(1'b0, 1'b0, 1'b1);
    end
    checkOutput("count_sel1", dutIf.cycle_count, 32'd8);

    // Enable dropped while high: full high phase, fall, park, then re-enable.
    resetDut(1'b1, 8'd5);
    for (int e = 1; e <= 35; e++) begin
      tick();
      if (e == 6) applyStimulus(1'b0, 8'd5);
      if (e == 30) applyStimulus(1'b1, 8'd5);
      if (e >= 6 && e <= 9) checkOutput("drop_high", 32'(dutIf.clock), 32'd1);
      else if (e == 10) checkEdge(1'b0, 1'b0, 1'b1);
      else if (e > 10 && e < 35) begin
        checkOutput("parked_clock", 32'(dutIf.clock), 32'd0);
        checkOutput("parked_rise", 32'(dutIf.clock_rise), 32'd0);
      end else if (e == 35) checkEdge(1'b1, 1'b1, 1'b0);
    end
    checkOutput("count_reenable", dutIf.cycle_count, 32'd2);

    // Async reset between edges while high with the rise strobe set.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clock", 32'(dutIf.clock), 32'd0);
    checkOutput("async_rise", 32'(dutIf.clock_rise), 32'd0);
    checkOutput("async_fall", 32'(dutIf.clock_fall), 32'd0);
    checkOutput("async_count", dutIf.cycle_count, 32'd0);

    // Counter wrap on the 4-bit instance: rise k lands on edge 2k-1.
    wrapIf.enable  = 1'b1;
    wrapIf.div_sel = 8'd1;
    resetDut(1'b0, 8'd5);
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e == 1) checkOutput("wrap_first_rise", 32'(wrapIf.clock_rise), 32'd1);
      if (e == 29) checkOutput("wrap_count_15", 32'(wrapIf.cycle_count), 32'd15);
      if (e == 31) checkOutput("wrap_count_16", 32'(wrapIf.cycle_count), 32'd0);
      if (e == 33) checkOutput("wrap_count_17", 32'(wrapIf.cycle_count), 32'd1);
    end
    checkOutput("parked_dut_clock", 32'(dutIf.clock), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
